// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: state encoding, default widths and index helper shared by the
// counter load arbiter and its round-robin picker.
package counter_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, CHECK, HOLD} ctrl_state_e;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_MOD_N = 10;
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);
  function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int i);
    return IW'((int'(p) + i) % N);
  endfunction
  // Walk from the far end back to ptr so the closest requester wins.
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[rot(ptr, i)]) begin
        gnt = '0;
        gnt[rot(ptr, i)] = 1'b1;
        gnt_id = rot(ptr, i);
      end
  end
endmodule

// File: rtl/counter_load_arbiter.sv
// counter_load_arbiter: round-robin sharing of the mod-N counter load port, with
// one-cycle load pulses, readback check and a programmable hold-off between grants.
module counter_load_arbiter import counter_ctrl_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MOD_N = DEF_MOD_N,
  parameter int HOLD_CYC = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           cnt_load,
  output logic [DATA_W-1:0]              cnt_load_data,
  input  logic [DATA_W-1:0]              cnt_count,
  output logic                           done_valid,
  output logic                           done_err,
  output logic [IW-1:0]                  done_id
);
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
  ctrl_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, done_id_q, done_id_d, gnt_id;
  logic [DATA_W-1:0] data_q, data_d, load_data_q, load_data_d, sel_data;
  logic [HW-1:0] hold_q, hold_d;
  logic [NUM_REQ-1:0] ready_q, ready_d, gnt;
  logic load_q, load_d, dv_q, dv_d, de_q, de_d;
  logic arb_ok, sel_ok, data_ok;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );
  assign sel_data = req_data[gnt_id];
  assign sel_ok = int'(sel_data) < MOD_N;
  assign data_ok = int'(data_q) < MOD_N;
  // The cycle that ends the enforced gap also arbitrates, so grants land exactly 2+HOLD_CYC apart.
  assign arb_ok = state_q == IDLE || (state_q == CHECK && HOLD_CYC == 0) ||
                  (state_q == HOLD && hold_q == '0);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    data_d = data_q;
    hold_d = hold_q;
    ready_d = '0;
    load_d = 1'b0;
    load_data_d = '0;
    dv_d = 1'b0;
    de_d = 1'b0;
    done_id_d = done_id_q;
    if (state_q == GRANT) begin
      ptr_d = IW'(next_idx(int'(id_q), NUM_REQ));
      hold_d = HOLD_INIT;
      state_d = data_ok ? CHECK : (HOLD_CYC == 0 ? IDLE : HOLD);
      dv_d = data_ok;
      done_id_d = id_q;
    end else if (state_q == CHECK) begin
      hold_d = HOLD_INIT;
      state_d = HOLD_CYC == 0 ? IDLE : HOLD;
    end else if (state_q == HOLD) begin
      hold_d = hold_q == '0 ? hold_q : hold_q - 1'b1;
      state_d = hold_q == '0 ? IDLE : HOLD;
    end
    if (arb_ok && |req_valid) begin
      state_d = GRANT;
      id_d = gnt_id;
      data_d = sel_data;
      ready_d = gnt;
      load_d = sel_ok;
      load_data_d = sel_ok ? sel_data : '0;
      dv_d = !sel_ok;
      de_d = !sel_ok;
      done_id_d = gnt_id;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      data_q <= '0;
      hold_q <= '0;
      ready_q <= '0;
      load_q <= 1'b0;
      load_data_q <= '0;
      dv_q <= 1'b0;
      de_q <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      data_q <= data_d;
      hold_q <= hold_d;
      ready_q <= ready_d;
      load_q <= load_d;
      load_data_q <= load_data_d;
      dv_q <= dv_d;
      de_q <= de_d;
      done_id_q <= done_id_d;
    end
  assign req_ready = ready_q;
  assign cnt_load = load_q;
  assign cnt_load_data = load_data_q;
  assign done_valid = dv_q;
  assign done_id = done_id_q;
  // Readback can only be judged once the counter has taken the load, i.e. during CHECK itself.
  assign done_err = de_q | (state_q == CHECK && cnt_count != data_q);
endmodule

// File: tb/tb_counter_load_arbiter.sv
// tb_counter_load_arbiter: table vectors, directed corner cases and a randomized run
// against a transaction-timeline model of the round-robin load arbiter.
module tb_counter_load_arbiter;
  localparam int N = 4, W = 4, M = 10, H = 2;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_valid0 = '0;
  logic [N-1:0][W-1:0] req_data = '0, req_data0 = '0;
  logic [N-1:0] req_ready, req_ready0;
  logic cnt_load, cnt_load0, done_valid, done_valid0, done_err, done_err0;
  logic [W-1:0] cnt_load_data, cnt_load_data0, cnt_count, cnt_count0, cnt_q, cnt0_q;
  logic [1:0] done_id, done_id0;
  bit stuck = 1'b0;
  int nchk = 0, npass = 0;
  typedef struct {int id; int data; bit stk; bit exp_load; bit exp_gerr; bit exp_cerr;} vec_t;
  typedef struct packed {logic [N-1:0] rdy; logic ld; logic [W-1:0] ldat; logic dv; logic de; logic [1:0] did;} exp_t;
  vec_t vecs[8];
  vec_t rv;
  exp_t e0, e1, e2;
  bit [N-1:0] pend;
  logic [N-1:0][W-1:0] pdata;
  int got, last_ld, ptr, next_dec, w;
  bit prev_ld;
  always #5 clk = ~clk;
  counter_load_arbiter #(.NUM_REQ(N), .DATA_W(W), .MOD_N(M), .HOLD_CYC(H)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cnt_load(cnt_load), .cnt_load_data(cnt_load_data),
    .cnt_count(cnt_count), .done_valid(done_valid), .done_err(done_err), .done_id(done_id)
  );
  counter_load_arbiter #(.NUM_REQ(N), .DATA_W(W), .MOD_N(M), .HOLD_CYC(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .cnt_load(cnt_load0), .cnt_load_data(cnt_load_data0),
    .cnt_count(cnt_count0), .done_valid(done_valid0), .done_err(done_err0), .done_id(done_id0)
  );
  // Mod-N counters standing in for the real counter instances.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      cnt0_q <= '0;
    end else begin
      cnt_q <= cnt_load ? cnt_load_data : W'((int'(cnt_q) + 1) % M);
      cnt0_q <= cnt_load0 ? cnt_load_data0 : W'((int'(cnt0_q) + 1) % M);
    end
  assign cnt_count = stuck ? W'(5) : cnt_q;
  assign cnt_count0 = cnt0_q;
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic xact(input vec_t v);
    stuck = v.stk;
    @(negedge clk);
    req_valid[v.id] = 1'b1;
    req_data[v.id] = W'(v.data);
    @(negedge clk);
    chk("grant_ready", int'(req_ready), 1 << v.id);
    chk("grant_load", int'(cnt_load), int'(v.exp_load));
    if (v.exp_load) chk("grant_ldata", int'(cnt_load_data), v.data);
    chk("grant_dv", int'(done_valid), int'(v.exp_gerr));
    chk("grant_derr", int'(done_err), int'(v.exp_gerr));
    if (v.exp_gerr) chk("grant_did", int'(done_id), v.id);
    req_valid[v.id] = 1'b0;
    if (v.exp_load) begin
      @(negedge clk);
      chk("check_dv", int'(done_valid), 1);
      chk("check_derr", int'(done_err), int'(v.exp_cerr));
      chk("check_did", int'(done_id), v.id);
      chk("check_load", int'(cnt_load), 0);
    end
    repeat (H + 1) @(negedge clk);
    stuck = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vecs = '{'{2, 7, 0, 1, 0, 0}, '{0, 0, 0, 1, 0, 0}, '{3, 9, 0, 1, 0, 0}, '{1, 10, 0, 0, 1, 0},
             '{1, 12, 0, 0, 1, 0}, '{2, 4, 0, 1, 0, 0}, '{0, 3, 1, 1, 0, 1}, '{3, 15, 0, 0, 1, 0}};
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_load", int'(cnt_load), 0);
    chk("rst_ldata", int'(cnt_load_data), 0);
    chk("rst_dv", int'(done_valid), 0);
    chk("rst_derr", int'(done_err), 0);
    chk("rst_did", int'(done_id), 0);
    reset_n = 1'b1;
    // All four at once: served 0..3, loads spaced 2+H apart.
    @(negedge clk);
    req_valid = 4'hf;
    req_data = {4'd4, 4'd3, 4'd2, 4'd1};
    got = 0;
    last_ld = -1;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("rr_order", int'(req_ready), 1 << got);
        chk("rr_ldata", int'(cnt_load_data), got + 1);
        if (got > 0) chk("rr_spacing", c - last_ld, 2 + H);
        last_ld = c;
        req_valid &= ~req_ready;
        got++;
      end
    end
    chk("rr_all_served", got, 4);
    req_valid = '0;
    repeat (H + 2) @(negedge clk);
    for (int i = 0; i < 8; i++) xact(vecs[i]);
    // Reset during GRANT: pointer must return to 0.
    rv = '{1, 5, 0, 1, 0, 0};
    xact(rv);
    @(negedge clk);
    req_valid = 4'b1100;
    req_data[2] = 4'd6;
    req_data[3] = 4'd8;
    @(negedge clk);
    chk("pre_rst_ready", int'(req_ready), 4);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_ready", int'(req_ready), 0);
    chk("async_rst_load", int'(cnt_load), 0);
    chk("async_rst_dv", int'(done_valid), 0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 4'b1001;
    req_data[0] = 4'd2;
    @(negedge clk);
    chk("post_rst_grant", int'(req_ready), 1);
    req_valid[0] = 1'b0;
    repeat (2 + H) @(negedge clk);
    chk("post_rst_next", int'(req_ready), 8);
    req_valid = '0;
    repeat (H + 2) @(negedge clk);
    // HOLD_CYC=0 instance with a continuous request from requester 1.
    req_valid0[1] = 1'b1;
    req_data0[1] = 4'd6;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("h0_ready", int'(req_ready0), (k % 2) * 2);
      chk("h0_load", int'(cnt_load0), k % 2);
      chk("h0_dv", int'(done_valid0), 1 - (k % 2));
      chk("h0_derr", int'(done_err0), 0);
    end
    req_valid0 = '0;
    // Randomized traffic against the timeline model.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    e1 = '0;
    e2 = '0;
    pend = '0;
    pdata = '0;
    ptr = 0;
    next_dec = 0;
    prev_ld = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e0 = e1;
      e1 = e2;
      e2 = '0;
      chk("rnd_ready", int'(req_ready), int'(e0.rdy));
      chk("rnd_load", int'(cnt_load), int'(e0.ld));
      if (e0.ld) chk("rnd_ldata", int'(cnt_load_data), int'(e0.ldat));
      chk("rnd_dv", int'(done_valid), int'(e0.dv));
      chk("rnd_derr", int'(done_err), int'(e0.de));
      if (e0.dv) chk("rnd_did", int'(done_id), int'(e0.did));
      chk("rnd_no_b2b", int'(prev_ld & cnt_load), 0);
      prev_ld = cnt_load;
      for (int i = 0; i < N; i++)
        if (e0.rdy[i]) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pdata[i] = W'($urandom_range(0, 12));
        end
      req_valid = pend;
      req_data = pdata;
      if (c >= next_dec && pend != '0) begin
        w = -1;
        for (int k = N - 1; k >= 0; k--)
          if (pend[(ptr + k) % N]) w = (ptr + k) % N;
        e1.rdy = N'(1 << w);
        if (int'(pdata[w]) < M) begin
          e1.ld = 1'b1;
          e1.ldat = pdata[w];
          e2.dv = 1'b1;
          e2.did = 2'(w);
          next_dec = c + 2 + H;
        end else begin
          e1.dv = 1'b1;
          e1.de = 1'b1;
          e1.did = 2'(w);
          next_dec = c + 1 + (H > 0 ? H : 1);
        end
        ptr = (w + 1) % N;
      end
    end
    req_valid = '0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
